// File: rtl/latency_sweep_sequencer_pkg.sv
// Shared types and constants for the latency sweep sequencer: FSM states,
// CSR word offsets and CTRL register bit positions.
package latency_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LAT,
        DATA,
        ACCUM,
        DONE
    } state_t;

    localparam logic [3:0] CSR_CTRL     = 4'd0;
    localparam logic [3:0] CSR_BASE     = 4'd1;
    localparam logic [3:0] CSR_STRIDE   = 4'd2;
    localparam logic [3:0] CSR_COUNT    = 4'd3;
    localparam logic [3:0] CSR_MIN      = 4'd4;
    localparam logic [3:0] CSR_MAX      = 4'd5;
    localparam logic [3:0] CSR_SUM_LO   = 4'd6;
    localparam logic [3:0] CSR_SUM_HI   = 4'd7;
    localparam logic [3:0] CSR_LAST     = 4'd8;
    localparam logic [3:0] CSR_SAMPLES  = 4'd9;
    localparam logic [3:0] CSR_CHECKSUM = 4'd10;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    // CTRL read bits
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;

endpackage

// File: rtl/latency_sweep_sequencer_if.sv
// Avalon-MM master bundle towards the memory latency tester (control port
// plus data port). master = sequencer side, slave = tester side.
interface latency_sweep_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  avm_ctl_write;
    logic                  avm_ctl_read;
    logic [31:0]           avm_ctl_writedata;
    logic [31:0]           avm_ctl_readdata;
    logic                  avm_ctl_waitrequest;
    logic                  avm_data_read;
    logic [DATA_WIDTH-1:0] avm_data_readdata;
    logic                  avm_data_waitrequest;

    modport master (
        output avm_ctl_write, avm_ctl_read, avm_ctl_writedata, avm_data_read,
        input  avm_ctl_readdata, avm_ctl_waitrequest, avm_data_readdata, avm_data_waitrequest
    );

    modport slave (
        input  avm_ctl_write, avm_ctl_read, avm_ctl_writedata, avm_data_read,
        output avm_ctl_readdata, avm_ctl_waitrequest, avm_data_readdata, avm_data_waitrequest
    );
endinterface

// File: rtl/latency_sweep_sequencer_stats.sv
// Running latency statistics: min, max, 64-bit wrapping sum and sample count.
// clear has priority over update.
module latency_stats #(
    parameter int LAT_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   update,
    input  logic [LAT_WIDTH-1:0]   lat,
    output logic [LAT_WIDTH-1:0]   min_lat,
    output logic [LAT_WIDTH-1:0]   max_lat,
    output logic [63:0]            sum,
    output logic [COUNT_WIDTH-1:0] samples
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_lat <= '1;
            max_lat <= '0;
            sum     <= '0;
            samples <= '0;
        end else if (clear) begin
            min_lat <= '1;
            max_lat <= '0;
            sum     <= '0;
            samples <= '0;
        end else if (update) begin
            if (lat < min_lat) min_lat <= lat;
            if (lat > max_lat) max_lat <= lat;
            sum     <= sum + 64'(lat);
            samples <= samples + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/latency_sweep_sequencer.sv
// Sweeps COUNT addresses through the latency tester and accumulates stats.
// Define LATENCY_SWEEP_CHECKSUM_EN to build the rotating-XOR data checksum.
module latency_sweep_sequencer
    import latency_sweep_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    latency_sweep_sequencer_if.master avm
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] base_q, stride_q, cur_addr;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [31:0]              lat_q;
    logic [DATA_WIDTH-1:0]    data_q, last_data;
    logic                     done_q;
    logic                     ctl_write_q, ctl_read_q, data_read_q;
    logic [31:0]              ctl_wdata_q;

    logic [31:0]              min_lat, max_lat;
    logic [63:0]              sum;
    logic [COUNT_WIDTH-1:0]   samples;
    logic [31:0]              checksum;

    logic busy, csr_wr_ok, start_acc, clear_acc, stats_clear, stats_update, last_sample;
    logic [ADDRESS_WIDTH-1:0] next_addr;

    // CSR reads are combinational and side-effect free, so the strobe is not needed
    logic unused_ok;
    assign unused_ok = avs_read;

    assign busy         = (state != IDLE);
    assign csr_wr_ok    = avs_write && !busy;
    assign start_acc    = csr_wr_ok && (avs_address == CSR_CTRL) && avs_writedata[CTRL_START];
    assign clear_acc    = csr_wr_ok && (avs_address == CSR_CTRL) && avs_writedata[CTRL_CLEAR];
    assign stats_clear  = start_acc || clear_acc;
    assign stats_update = (state == ACCUM);
    assign next_addr    = cur_addr + stride_q;
    assign last_sample  = ((samples + COUNT_WIDTH'(1)) == count_q);

    assign avm.avm_ctl_write     = ctl_write_q;
    assign avm.avm_ctl_read      = ctl_read_q;
    assign avm.avm_ctl_writedata = ctl_wdata_q;
    assign avm.avm_data_read     = data_read_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
        end else if (csr_wr_ok) begin
            case (avs_address)
                CSR_BASE:   base_q   <= avs_writedata[ADDRESS_WIDTH-1:0];
                CSR_STRIDE: stride_q <= avs_writedata[ADDRESS_WIDTH-1:0];
                CSR_COUNT:  count_q  <= avs_writedata[COUNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            lat_q       <= '0;
            data_q      <= '0;
            last_data   <= '0;
            done_q      <= 1'b0;
            ctl_write_q <= 1'b0;
            ctl_read_q  <= 1'b0;
            data_read_q <= 1'b0;
            ctl_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stats_clear) done_q <= 1'b0;
                    if (start_acc) begin
                        cur_addr <= base_q;
                        if (count_q == '0) begin
                            state <= DONE;
                        end else begin
                            state       <= ISSUE;
                            ctl_write_q <= 1'b1;
                            ctl_wdata_q <= 32'(base_q);
                        end
                    end
                end
                ISSUE: if (!avm.avm_ctl_waitrequest) begin
                    ctl_write_q <= 1'b0;
                    ctl_read_q  <= 1'b1;
                    state       <= LAT;
                end
                LAT: if (!avm.avm_ctl_waitrequest) begin
                    lat_q       <= avm.avm_ctl_readdata;
                    ctl_read_q  <= 1'b0;
                    data_read_q <= 1'b1;
                    state       <= DATA;
                end
                DATA: if (!avm.avm_data_waitrequest) begin
                    data_q      <= avm.avm_data_readdata;
                    data_read_q <= 1'b0;
                    state       <= ACCUM;
                end
                ACCUM: begin
                    last_data <= data_q;
                    cur_addr  <= next_addr;
                    if (last_sample) begin
                        state <= DONE;
                    end else begin
                        state       <= ISSUE;
                        ctl_write_q <= 1'b1;
                        ctl_wdata_q <= 32'(next_addr);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    latency_stats #(
        .LAT_WIDTH   (32),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_stats (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (stats_clear),
        .update  (stats_update),
        .lat     (lat_q),
        .min_lat (min_lat),
        .max_lat (max_lat),
        .sum     (sum),
        .samples (samples)
    );

`ifdef LATENCY_SWEEP_CHECKSUM_EN
    logic [31:0] checksum_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          checksum_q <= '0;
        else if (stats_clear)  checksum_q <= '0;
        else if (stats_update) checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ 32'(data_q);
    end
    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            CSR_CTRL: begin
                avs_readdata[CTRL_BUSY] = busy;
                avs_readdata[CTRL_DONE] = done_q;
            end
            CSR_BASE:     avs_readdata = 32'(base_q);
            CSR_STRIDE:   avs_readdata = 32'(stride_q);
            CSR_COUNT:    avs_readdata = 32'(count_q);
            CSR_MIN:      avs_readdata = min_lat;
            CSR_MAX:      avs_readdata = max_lat;
            CSR_SUM_LO:   avs_readdata = sum[31:0];
            CSR_SUM_HI:   avs_readdata = sum[63:32];
            CSR_LAST:     avs_readdata = 32'(last_data);
            CSR_SAMPLES:  avs_readdata = 32'(samples);
            CSR_CHECKSUM: avs_readdata = checksum;
            default: ;
        endcase
    end

endmodule
